// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader.
package loader_pkg;

  // Frame parser states
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN0 = 3'd1,
    LEN1 = 3'd2,
    DATA = 3'd3,
    CSUM = 3'd4,
    DONE = 3'd5
  } loader_state_e;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int         COUNT_W       = 16;

  // Running frame checksum: XOR of every data byte
  function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] data);
    return acc ^ data;
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Packs a little-endian byte stream into 32-bit words with a one-cycle word strobe.
module byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [1:0]  byte_idx,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  idx_r;
  logic [23:0] low_r;
  logic [31:0] word_r;
  logic        word_valid_r;

  // Collect the three low bytes, then emit the full word on the fourth
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_r        <= 2'd0;
      low_r        <= 24'd0;
      word_r       <= 32'd0;
      word_valid_r <= 1'b0;
    end else if (clear) begin
      idx_r        <= 2'd0;
      low_r        <= 24'd0;
      word_valid_r <= 1'b0;
    end else begin
      word_valid_r <= 1'b0;
      if (byte_valid) begin
        case (idx_r)
          2'd0:    low_r[7:0]   <= byte_data;
          2'd1:    low_r[15:8]  <= byte_data;
          2'd2:    low_r[23:16] <= byte_data;
          2'd3: begin
            word_r       <= {byte_data, low_r};
            word_valid_r <= 1'b1;
          end
          default: low_r <= low_r;
        endcase
        idx_r <= idx_r + 2'd1;
      end
    end
  end

  assign byte_idx   = idx_r;
  assign word       = word_r;
  assign word_valid = word_valid_r;

endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream program loader: writes a checksum-verified image into
// instruction memory and holds the core in reset until the image is complete.
module prog_loader
  import loader_pkg::*;
#(
  parameter int         ADDR_W    = 8,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_rst,
  output logic              load_done,
  output logic              load_err
);

  // Largest accepted word count is 2^ADDR_W; one extra bit keeps the compare exact
  localparam logic [COUNT_W:0] MAX_WORDS = {{COUNT_W{1'b0}}, 1'b1} << ADDR_W;

  loader_state_e       state_r, state_next_s;
  logic [7:0]          count_lo_r;
  logic [COUNT_W-1:0]  remaining_r;
  logic [7:0]          acc_r;
  logic [ADDR_W-1:0]   addr_r;
  logic                rx_ready_r, cpu_rst_r, load_done_r, load_err_r;
  logic                xfer_s, sync_s, err_s, data_byte_s;
  logic [COUNT_W-1:0]  count_s;
  logic [1:0]          byte_idx_s;
  logic [31:0]         word_s;
  logic                word_valid_s;

  assign xfer_s  = rx_valid & rx_ready_r;
  assign count_s = {rx_data, count_lo_r};

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (sync_s),
    .byte_valid (data_byte_s),
    .byte_data  (rx_data),
    .byte_idx   (byte_idx_s),
    .word       (word_s),
    .word_valid (word_valid_s)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode and per-byte control strobes
  always_comb begin
    state_next_s = state_r;
    sync_s       = 1'b0;
    err_s        = 1'b0;
    data_byte_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (xfer_s && (rx_data == SYNC_BYTE)) begin
          state_next_s = LEN0;
          sync_s       = 1'b1;
        end else begin
          state_next_s = IDLE;
        end
      end
      LEN0: begin
        if (xfer_s) begin
          state_next_s = LEN1;
        end else begin
          state_next_s = LEN0;
        end
      end
      LEN1: begin
        if (!xfer_s) begin
          state_next_s = LEN1;
        end else if ({1'b0, count_s} > MAX_WORDS) begin
          state_next_s = IDLE;
          err_s        = 1'b1;
        end else if (count_s == {COUNT_W{1'b0}}) begin
          state_next_s = CSUM;
        end else begin
          state_next_s = DATA;
        end
      end
      DATA: begin
        if (xfer_s) begin
          data_byte_s = 1'b1;
          if ((byte_idx_s == 2'd3) && (remaining_r == {{(COUNT_W-1){1'b0}}, 1'b1})) begin
            state_next_s = CSUM;
          end else begin
            state_next_s = DATA;
          end
        end else begin
          state_next_s = DATA;
        end
      end
      CSUM: begin
        if (!xfer_s) begin
          state_next_s = CSUM;
        end else if (rx_data == acc_r) begin
          state_next_s = DONE;
        end else begin
          state_next_s = IDLE;
          err_s        = 1'b1;
        end
      end
      DONE: begin
        state_next_s = DONE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Frame bookkeeping (count, checksum, address) and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      count_lo_r  <= 8'd0;
      remaining_r <= {COUNT_W{1'b0}};
      acc_r       <= 8'd0;
      addr_r      <= {ADDR_W{1'b0}};
      rx_ready_r  <= 1'b0;
      cpu_rst_r   <= 1'b1;
      load_done_r <= 1'b0;
      load_err_r  <= 1'b0;
    end else begin
      rx_ready_r  <= (state_next_s != DONE);
      cpu_rst_r   <= (state_next_s != DONE);
      load_done_r <= (state_next_s == DONE);
      if (sync_s) begin
        load_err_r <= 1'b0;
      end else if (err_s) begin
        load_err_r <= 1'b1;
      end
      if ((state_r == LEN0) && xfer_s) begin
        count_lo_r <= rx_data;
      end
      if ((state_r == LEN1) && xfer_s) begin
        remaining_r <= count_s;
      end
      if (sync_s) begin
        acc_r <= 8'd0;
      end else if (data_byte_s) begin
        acc_r <= csum_update(acc_r, rx_data);
      end
      if (data_byte_s && (byte_idx_s == 2'd3)) begin
        remaining_r <= remaining_r - {{(COUNT_W-1){1'b0}}, 1'b1};
      end
      // The address advances once the write strobe for it has been presented
      if (sync_s) begin
        addr_r <= {ADDR_W{1'b0}};
      end else if (word_valid_s) begin
        addr_r <= addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign rx_ready  = rx_ready_r;
  assign mem_we    = word_valid_s;
  assign mem_addr  = addr_r;
  assign mem_wdata = word_s;
  assign cpu_rst   = cpu_rst_r;
  assign load_done = load_done_r;
  assign load_err  = load_err_r;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: per-cycle vector table plus gap and mid-frame reset sequences.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_rst;
  logic        load_done;
  logic        load_err;

  prog_loader #(.ADDR_W(8), .SYNC_BYTE(8'hA5)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_rst   (cpu_rst),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  // One cycle: inputs applied for the edge, outputs expected just after it
  typedef struct {
    logic        r;
    logic        v;
    logic [7:0]  d;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        done;
    logic        err;
  } vec_t;

  vec_t        tbl[$];
  logic        cur_err;
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  good_frame [12];
  logic [31:0] good_words [2];

  function automatic void push(input logic r, input logic v, input logic [7:0] d, input logic we,
                               input logic [7:0] addr, input logic [31:0] wdata, input logic done);
    vec_t e;
    e.r = r; e.v = v; e.d = d; e.we = we; e.addr = addr; e.wdata = wdata; e.done = done; e.err = cur_err;
    tbl.push_back(e);
  endfunction

  function automatic void t_rst();
    cur_err = 1'b0;
    push(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 32'h0, 1'b0);
  endfunction
  function automatic void t_idle(input logic [7:0] d);
    push(1'b0, 1'b0, d, 1'b0, 8'h00, 32'h0, 1'b0);
  endfunction
  function automatic void t_sync();
    cur_err = 1'b0;
    push(1'b0, 1'b1, 8'hA5, 1'b0, 8'h00, 32'h0, 1'b0);
  endfunction
  function automatic void t_b(input logic [7:0] d);
    push(1'b0, 1'b1, d, 1'b0, 8'h00, 32'h0, 1'b0);
  endfunction
  function automatic void t_w(input logic [7:0] d, input logic [7:0] addr, input logic [31:0] wdata);
    push(1'b0, 1'b1, d, 1'b1, addr, wdata, 1'b0);
  endfunction
  function automatic void t_fin(input logic [7:0] d);
    push(1'b0, 1'b1, d, 1'b0, 8'h00, 32'h0, 1'b1);
  endfunction
  function automatic void t_bad(input logic [7:0] d);
    cur_err = 1'b1;
    push(1'b0, 1'b1, d, 1'b0, 8'h00, 32'h0, 1'b0);
  endfunction

  // Two-word frame body after the sync byte, with a chosen checksum record
  function automatic void t_two_word_body();
    t_b(8'h02); t_b(8'h00);
    t_b(8'h13); t_b(8'h00); t_b(8'h10); t_w(8'h00, 8'd0, 32'h00100013);
    t_b(8'hB3); t_b(8'h81); t_b(8'h20); t_w(8'h00, 8'd1, 32'h002081B3);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [7:0] d);
    rst      = r;
    rx_valid = v;
    rx_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rdy"},   {31'd0, rx_ready},  32'd0);
    check({tag, "_we"},    {31'd0, mem_we},    32'd0);
    check({tag, "_addr"},  {24'd0, mem_addr},  32'd0);
    check({tag, "_wdata"}, mem_wdata,          32'd0);
    check({tag, "_cpu"},   {31'd0, cpu_rst},   32'd1);
    check({tag, "_done"},  {31'd0, load_done}, 32'd0);
    check({tag, "_err"},   {31'd0, load_err},  32'd0);
  endtask

  // Sends the good two-word frame with up to max_gap idle cycles before each byte
  task automatic send_frame(input string tag, input int max_gap);
    int wr = 0;
    for (int i = 0; i < 12; i++) begin
      int gaps = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      for (int g = 0; g < gaps; g++) begin
        step(1'b0, 1'b0, 8'($urandom_range(0, 255)));
        check({tag, "_gap_we"}, {31'd0, mem_we}, 32'd0);
      end
      step(1'b0, 1'b1, good_frame[i]);
      if (i == 6 || i == 10) begin
        check({tag, "_we"},    {31'd0, mem_we},   32'd1);
        check({tag, "_addr"},  {24'd0, mem_addr}, wr);
        check({tag, "_wdata"}, mem_wdata,         good_words[wr]);
        wr++;
      end else begin
        check({tag, "_nowe"}, {31'd0, mem_we}, 32'd0);
      end
    end
    check({tag, "_done"}, {31'd0, load_done}, 32'd1);
    check({tag, "_cpu"},  {31'd0, cpu_rst},   32'd0);
    check({tag, "_rdy"},  {31'd0, rx_ready},  32'd0);
    check({tag, "_err"},  {31'd0, load_err},  32'd0);
  endtask

  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    cur_err  = 1'b0;
    good_frame = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h10, 8'h00,
                   8'hB3, 8'h81, 8'h20, 8'h00, 8'h11};
    good_words = '{32'h00100013, 32'h002081B3};

    // Good two-word frame, checksum 13^00^10^00^B3^81^20^00 = 11
    t_rst(); t_idle(8'hA5);
    t_sync(); t_two_word_body(); t_fin(8'h11);
    // Wrong checksum, then a correct frame clears the error
    t_rst(); t_idle(8'h00);
    t_sync(); t_two_word_body(); t_bad(8'h12);
    t_idle(8'h00);
    t_sync(); t_two_word_body(); t_fin(8'h11);
    // Leading garbage, then one-word frame DEADBEEF with checksum 22
    t_rst(); t_idle(8'h00);
    t_b(8'h00); t_b(8'hFF); t_b(8'h5A);
    t_sync(); t_b(8'h01); t_b(8'h00);
    t_b(8'hEF); t_b(8'hBE); t_b(8'hAD); t_w(8'hDE, 8'd0, 32'hDEADBEEF);
    t_fin(8'h22);
    // Count 257 rejected, then an empty frame completes
    t_rst(); t_idle(8'h00);
    t_sync(); t_b(8'h01); t_bad(8'h01);
    t_idle(8'hA5);
    t_sync(); t_b(8'h00); t_b(8'h00); t_fin(8'h00);
    // Count 256 is the largest accepted image
    t_rst(); t_idle(8'h00);
    t_sync(); t_b(8'h00); t_b(8'h01); t_b(8'h00); t_b(8'h00);

    for (int i = 0; i < tbl.size(); i++) begin
      vec_t e = tbl[i];
      step(e.r, e.v, e.d);
      check($sformatf("v%0d_we", i),   {31'd0, mem_we},    {31'd0, e.we});
      check($sformatf("v%0d_done", i), {31'd0, load_done}, {31'd0, e.done});
      check($sformatf("v%0d_cpu", i),  {31'd0, cpu_rst},   {31'd0, ~e.done});
      check($sformatf("v%0d_err", i),  {31'd0, load_err},  {31'd0, e.err});
      check($sformatf("v%0d_rdy", i),  {31'd0, rx_ready},  {31'd0, ~(e.r | e.done)});
      if (e.we || e.r) begin
        check($sformatf("v%0d_addr", i),  {24'd0, mem_addr}, {24'd0, e.addr});
        check($sformatf("v%0d_wdata", i), mem_wdata,         e.wdata);
      end
    end

    // Random rx_valid gaps on the two-word frame
    step(1'b1, 1'b0, 8'h00);
    check_reset_values("gap_rst");
    step(1'b0, 1'b0, 8'h00);
    send_frame("gap", 3);

    // Reset after six data bytes, then a full frame from address 0
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 9; i++) begin
      step(1'b0, 1'b1, good_frame[i]);
    end
    check("mid_pre_wdata", mem_wdata, 32'h00100013);
    step(1'b1, 1'b0, 8'h00);
    check_reset_values("mid_rst");
    step(1'b0, 1'b0, 8'h00);
    check("mid_rdy_back", {31'd0, rx_ready}, 32'd1);
    send_frame("mid", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Hardware program loader that receives a framed byte stream and writes 32-bit little-endian words into the processor's instruction memory through its write port. It holds the core in reset until a complete, checksum-verified image is in memory, replacing simulation-only memory preloading for FPGA bring-up. It sits between a byte source (UART receiver or debug bridge) and the `inst_mem` write port / `processor` reset input.

## Interface
- `ADDR_W`, 8: instruction-memory word-address width; maximum image is 2^ADDR_W words.
- `SYNC_BYTE`, 8'hA5: frame start marker.

Ports:
- `clk`  in  1  system clock; only clock.
- `rst`  in  1  reset, synchronous and active-high.
- `rx_data`  in  8  incoming byte.
- `rx_valid`  in  1  `rx_data` is valid.
- `rx_ready`  out  1  loader accepts the byte; transfer occurs when `rx_valid && rx_ready` on a rising edge.
- `mem_we`  out  1  one-cycle instruction-memory write strobe.
- `mem_addr`  out  ADDR_W  word address of the write.
- `mem_wdata`  out  32  word to write.
- `cpu_rst`  out  1  reset to the processor core.
- `load_done`  out  1  image loaded and verified.
- `load_err`  out  1  last frame was rejected (sticky until the next sync byte is accepted).

## Operation
- Frame format: `SYNC_BYTE`, count low byte, count high byte (16-bit word count N), 4·N data bytes (LSB first per word), 1 checksum byte equal to the XOR of all data bytes.
- FSM states: IDLE, LEN0, LEN1, DATA, CSUM, DONE.
  - IDLE: accept bytes; non-sync bytes are discarded. Sync byte -> LEN0; clears `load_err`, the checksum accumulator, and the word address.
  - LEN0 -> LEN1 on accepted byte; latch count[7:0].
  - LEN1: latch count[15:8]. If N > 2^ADDR_W -> IDLE with `load_err`=1. If N = 0 -> CSUM. Otherwise -> DATA.
  - DATA: a 2-bit byte index packs bytes into a word, and each byte is XORed into the checksum. On the 4th byte: issue a write, increment the address, decrement the remaining count. After the last word -> CSUM.
  - CSUM: on accepted byte, if it matches the accumulator -> DONE, otherwise -> IDLE with `load_err`=1.
  - DONE: terminal until `rst`. `rx_ready`=0, `load_done`=1, `cpu_rst`=0.
- `rx_ready`=1 in every state except DONE. Back-pressure is never applied mid-frame.
- Words already written by a rejected frame stay in memory. `cpu_rst` stays 1, and a new frame restarts at address 0.
- Addresses never wrap, because N is bounded before DATA is entered.

## Timing
- Reset values: `rx_ready`=0 in the reset cycle and 1 from the first cycle after `rst` deasserts (state IDLE). Also at reset: `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `cpu_rst`=1, `load_done`=0, `load_err`=0.
- All outputs are registered.
- `mem_we` goes high exactly one cycle after the handshake of a word's 4th byte, for one cycle, with `mem_addr`/`mem_wdata` valid in the same cycle.
- `cpu_rst` falls and `load_done` rises on the cycle after a matching checksum handshake.
- `load_err` rises on the cycle after the rejecting handshake.
- Gaps in `rx_valid` at any point stall the FSM with no state change.
- `rst` mid-frame: the FSM returns to IDLE on the next edge and all outputs take their reset values. Memory contents are untouched.
- Throughput: one byte per cycle sustained, i.e. one word written every 4 cycles.

## Structure
- Package `loader_pkg`:
  - state enum `loader_state_e` (IDLE, LEN0, LEN1, DATA, CSUM, DONE);
  - `SYNC_BYTE` default constant;
  - `COUNT_W` = 16.
- Sub-module `byte_packer`: accepts a byte strobe and emits a 32-bit word plus a one-cycle word strobe. It has a clear input, which the FSM pulses on sync.
- `prog_loader` itself owns the FSM, count, address, and checksum.

## Test plan
- Frame A5 02 00 | 13 00 10 00 | B3 81 20 00 | checksum = XOR of the eight data bytes:
  - writes 0x00100013 @0 and 0x002081B3 @1;
  - `load_done`=1 and `cpu_rst`=0 one cycle after the checksum byte.
- Same frame with a wrong checksum byte:
  - both words are still written;
  - `load_err`=1, `cpu_rst` stays 1, FSM is in IDLE;
  - a following correct frame completes and clears `load_err`.
- Leading garbage 00 FF 5A before A5 01 00 EF BE AD DE 22: garbage is ignored, then 0xDEADBEEF is written @0 and the load completes.
- Count 0x0101 with `ADDR_W`=8: `load_err`=1 after LEN1 and no `mem_we` pulse. Frame A5 00 00 00 completes with no writes.
- Random `rx_valid` gaps on the two-word frame: identical writes and completion, with each `mem_we` pulse one cycle after the corresponding 4th-byte handshake.
- Assert `rst` after 6 data bytes:
  - all outputs return to reset values;
  - a subsequent full frame writes from address 0 and completes.
